// File: rtl/seg7_scan_ctrl.sv
// Multiplexed refresh controller for a common-anode 7-segment display.
// Each slot is blank gap, lit digit, then one advance cycle; the value is double-buffered on frame wrap.
module seg7_scan_ctrl #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int DIGITS       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  input  logic        load,
  output logic        load_ack,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int TMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PRE_LAST = TW'(PRESCALE - 1);
  localparam logic [TW-1:0] BLK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);
  localparam logic [3:0]    NDIG     = 4'(DIGITS);

  typedef enum logic [1:0] {
    BLANK   = 2'd0,
    SHOW    = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic [2:0]     idx_r, idx_s;
  logic [31:0]    staging_r, staging_s;
  logic [31:0]    shadow_r, shadow_s;
  logic           pending_r, pending_s;
  logic [7:0]     anodes_s;
  logic [6:0]     segments_s;
  logic           dp_s;
  logic           frame_done_s;
  logic           load_ack_s;
  logic           wrap_s;
  logic           apply_s;
  logic           lit_s;
  logic [31:0]    shifted_s;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      4'hF:    hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  // Next-state, buffer and next-output logic; outputs are derived from the next state so they register on the transition edge.
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r + TW'(1);
    idx_s        = idx_r;
    anodes_s     = 8'hFF;
    segments_s   = 7'h7F;
    dp_s         = 1'b1;
    case (state_r)
      BLANK: begin
        if (timer_r == BLK_LAST) begin
          state_s = SHOW;
          timer_s = '0;
        end else begin
          state_s = BLANK;
        end
      end
      SHOW: begin
        if (timer_r == PRE_LAST) begin
          state_s = ADVANCE;
          timer_s = '0;
        end else begin
          state_s = SHOW;
        end
      end
      ADVANCE: begin
        state_s = BLANK;
        timer_s = '0;
        idx_s   = (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
      end
      default: begin
        state_s = BLANK;
        timer_s = '0;
        idx_s   = 3'd0;
      end
    endcase

    // A load in the wrap cycle lands in staging only; shadow takes the previous staging.
    wrap_s    = (state_r == ADVANCE) && (idx_r == IDX_LAST);
    apply_s   = wrap_s && pending_r;
    staging_s = load ? value : staging_r;
    shadow_s  = apply_s ? staging_r : shadow_r;
    if (load) begin
      pending_s = 1'b1;
    end else if (apply_s) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end

    lit_s     = (state_s == SHOW) && digit_en[idx_s] && ({1'b0, idx_s} < NDIG);
    shifted_s = shadow_s >> {idx_s, 2'b00};
    if (lit_s) begin
      anodes_s[idx_s] = 1'b0;
    end else begin
      anodes_s = 8'hFF;
    end
    if (state_s == SHOW) begin
      segments_s = hex7(shifted_s[3:0]);
      dp_s       = lit_s ? ~dp_mask[idx_s] : 1'b1;
    end else begin
      segments_s = 7'h7F;
      dp_s       = 1'b1;
    end

    frame_done_s = (state_s == ADVANCE) && (idx_s == IDX_LAST);
    load_ack_s   = frame_done_s && pending_s;
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BLANK;
      timer_r    <= '0;
      idx_r      <= 3'd0;
      staging_r  <= 32'd0;
      shadow_r   <= 32'd0;
      pending_r  <= 1'b0;
      anodes     <= 8'hFF;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      idx_r      <= idx_s;
      staging_r  <= staging_s;
      shadow_r   <= shadow_s;
      pending_r  <= pending_s;
      anodes     <= anodes_s;
      segments   <= segments_s;
      dp         <= dp_s;
      frame_done <= frame_done_s;
      load_ack   <= load_ack_s;
    end
  end

  assign digit_idx = idx_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: per-slot expectations are queued by the stimulus
// and compared by monitors that reconstruct each observed slot (8-digit and 4-digit instances).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = 32'd0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic        load = 1'b0;

  logic        load_ack8, dp8, frame_done8;
  logic [7:0]  anodes8;
  logic [6:0]  segments8;
  logic [2:0]  digit_idx8;
  logic        load_ack4, dp4, frame_done4;
  logic [7:0]  anodes4;
  logic [6:0]  segments4;
  logic [2:0]  digit_idx4;

  seg7_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(2), .DIGITS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask), .digit_en(digit_en),
    .load(load), .load_ack(load_ack8), .anodes(anodes8), .segments(segments8),
    .dp(dp8), .digit_idx(digit_idx8), .frame_done(frame_done8)
  );

  seg7_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(2), .DIGITS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask), .digit_en(digit_en),
    .load(load), .load_ack(load_ack4), .anodes(anodes4), .segments(segments4),
    .dp(dp4), .digit_idx(digit_idx4), .frame_done(frame_done4)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] an;
    logic [6:0] lit;
    logic [6:0] seg;
    logic       dp;
    logic [6:0] fd;
    logic [6:0] ack;
    logic       blank_ok;
    logic [3:0] len;
  } slot_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [6:0] fd;
    logic       hi;
    logic [3:0] len;
  } s4_t;

  slot_t q8[$];
  s4_t   q4[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One 7-cycle slot: queue the expectation, optionally pulse load in its first cycle.
  task automatic run_slot(input int k, input logic [31:0] shown, input bit ack,
                          input bit ld, input logic [31:0] ldv);
    slot_t e;
    s4_t   f;
    bit    lit;
    lit        = digit_en[k];
    e.idx      = 3'(k);
    e.an       = lit ? ~(8'h01 << k) : 8'hFF;
    e.lit      = lit ? 7'b0111100 : 7'b0000000;
    e.seg      = HEX_REF[shown[k*4 +: 4]];
    e.dp       = lit ? ~dp_mask[k] : 1'b1;
    e.fd       = (k == 7) ? 7'b1000000 : 7'b0000000;
    e.ack      = (k == 7 && ack) ? 7'b1000000 : 7'b0000000;
    e.blank_ok = 1'b1;
    e.len      = 4'd7;
    q8.push_back(e);
    f.idx = 3'(k % 4);
    f.fd  = (k % 4 == 3) ? 7'b1000000 : 7'b0000000;
    f.hi  = 1'b0;
    f.len = 4'd7;
    q4.push_back(f);
    if (ld) begin
      value = ldv;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (6) @(posedge clk);
    end else begin
      repeat (7) @(posedge clk);
    end
    #1;
  endtask

  task automatic run_frame(input logic [31:0] shown, input int la, input logic [31:0] va,
                           input int lb, input logic [31:0] vb, input bit ack);
    for (int k = 0; k < 8; k++) begin
      run_slot(k, shown, ack, (k == la) || (k == lb), (k == la) ? va : vb);
    end
  endtask

  // Monitor for the 8-digit instance: a slot closes when digit_idx moves on.
  initial begin : mon8
    slot_t o, e;
    int    pos;
    pos = 0;
    o   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0;
      end else begin
        if (pos > 0 && (digit_idx8 != o.idx || pos >= 15)) begin
          o.len = 4'(pos);
          if (q8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s8_unexpected: slot idx %0d observed, none queued", o.idx);
          end else begin
            e = q8.pop_front();
            check($sformatf("s8[%0d].idx", e.idx), 32'(o.idx), 32'(e.idx));
            check($sformatf("s8[%0d].anodes", e.idx), 32'(o.an), 32'(e.an));
            check($sformatf("s8[%0d].lit_cycles", e.idx), 32'(o.lit), 32'(e.lit));
            check($sformatf("s8[%0d].segments", e.idx), 32'(o.seg), 32'(e.seg));
            check($sformatf("s8[%0d].dp", e.idx), 32'(o.dp), 32'(e.dp));
            check($sformatf("s8[%0d].frame_done", e.idx), 32'(o.fd), 32'(e.fd));
            check($sformatf("s8[%0d].load_ack", e.idx), 32'(o.ack), 32'(e.ack));
            check($sformatf("s8[%0d].blank", e.idx), 32'(o.blank_ok), 32'(e.blank_ok));
            check($sformatf("s8[%0d].len", e.idx), 32'(o.len), 32'(e.len));
          end
          pos = 0;
        end
        if (pos == 0) begin
          o          = '0;
          o.idx      = digit_idx8;
          o.an       = 8'hFF;
          o.blank_ok = 1'b1;
        end
        if (pos < 7) begin
          if (anodes8 != 8'hFF) begin
            o.lit[pos] = 1'b1;
            o.an       = anodes8;
          end
          o.fd[pos]  = frame_done8;
          o.ack[pos] = load_ack8;
          if (pos == 3) begin
            o.seg = segments8;
            o.dp  = dp8;
          end
          if ((pos < 2 || pos == 6) && (segments8 !== 7'h7F || dp8 !== 1'b1)) o.blank_ok = 1'b0;
        end
        pos++;
      end
    end
  end

  // Monitor for the 4-digit instance: index sequence, frame_done placement, upper anodes.
  initial begin : mon4
    s4_t o, e;
    int  pos;
    pos = 0;
    o   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0;
      end else begin
        if (pos > 0 && (digit_idx4 != o.idx || pos >= 15)) begin
          o.len = 4'(pos);
          if (q4.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s4_unexpected: slot idx %0d observed, none queued", o.idx);
          end else begin
            e = q4.pop_front();
            check($sformatf("s4[%0d].idx", e.idx), 32'(o.idx), 32'(e.idx));
            check($sformatf("s4[%0d].frame_done", e.idx), 32'(o.fd), 32'(e.fd));
            check($sformatf("s4[%0d].upper_anodes_low", e.idx), 32'(o.hi), 32'(e.hi));
            check($sformatf("s4[%0d].len", e.idx), 32'(o.len), 32'(e.len));
          end
          pos = 0;
        end
        if (pos == 0) begin
          o     = '0;
          o.idx = digit_idx4;
        end
        if (anodes4[7:4] != 4'hF) o.hi = 1'b1;
        if (pos < 7) o.fd[pos] = frame_done4;
        pos++;
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst.anodes", 32'(anodes8), 32'h0000_00FF);
    check("rst.segments", 32'(segments8), 32'h0000_007F);
    check("rst.dp", 32'(dp8), 32'd1);
    check("rst.frame_done", 32'(frame_done8), 32'd0);
    check("rst.load_ack", 32'(load_ack8), 32'd0);
    check("rst.digit_idx", 32'(digit_idx8), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frame A: zeros shown, load mid-frame applied at wrap.
    run_frame(32'h0000_0000, 3, 32'h7654_3210, -1, 32'h0, 1'b1);
    // Frame B: new value visible; two loads collapse into one ack.
    run_frame(32'h7654_3210, 1, 32'h1111_1111, 4, 32'hFFFF_FFFF, 1'b1);
    // Frame C: lower digits disabled, dp requested on a dark digit.
    digit_en = 8'hF0;
    dp_mask  = 8'h01;
    run_frame(32'hFFFF_FFFF, -1, 32'h0, -1, 32'h0, 1'b0);
    // Frame D: load pending, then reset during SHOW of digit 5.
    digit_en = 8'hFF;
    dp_mask  = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      run_slot(k, 32'hFFFF_FFFF, 1'b0, k == 2, 32'hC0DE_1234);
    end
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst.anodes", 32'(anodes8), 32'h0000_00DF);
    check("pre_rst.dp", 32'(dp8), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst.anodes", 32'(anodes8), 32'h0000_00FF);
    check("mid_rst.segments", 32'(segments8), 32'h0000_007F);
    check("mid_rst.dp", 32'(dp8), 32'd1);
    check("mid_rst.digit_idx", 32'(digit_idx8), 32'd0);
    check("mid_rst.anodes4", 32'(anodes4), 32'h0000_00FF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Frame E: pending load discarded, zeros shown, no ack.
    dp_mask = 8'h00;
    run_frame(32'h0000_0000, -1, 32'h0, -1, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Refresh scheduler for the 8-digit, common-anode 7-segment display on the board.
- Time-multiplexes a 32-bit hex value across the digits, one digit at a time.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries and never tear mid-frame.
- Sits between the application datapath and the board anode/cathode pins.

Parameters:
- PRESCALE, default 100000: cycles each digit is lit per slot (1 ms at 100 MHz); must be >= 1.
- BLANK_CYCLES, default 1000: cycles all anodes are off before each digit is lit; must be >= 1.
- DIGITS, default 8: number of scanned digits, 1..8. Anodes at or above DIGITS stay off permanently.

Ports:
- clk  in  1: system clock; all state changes on its rising edge.
- rst_n  in  1: active-low reset, asynchronous assert.
- value  in  32: hex nibbles; digit k shows value[4k+3:4k].
- dp_mask  in  8: bit k=1 lights the decimal point of digit k; sampled live, not buffered.
- digit_en  in  8: bit k=0 keeps digit k dark while its slot is still consumed; sampled live.
- load  in  1: request to capture value; level sampled each cycle.
- load_ack  out  1: one-cycle pulse when a captured value becomes the displayed value.
- anodes  out  8: active-low; at most one bit low.
- segments  out  7: active-low, bit order {g,f,e,d,c,b,a}.
- dp  out  1: active-low decimal point.
- digit_idx  out  3: index of the current slot.
- frame_done  out  1: one-cycle pulse at digit wrap.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=BLANK, timer=0, digit_idx=0.
  - anodes=8'hFF, segments=7'h7F, dp=1.
  - frame_done=0, load_ack=0.
  - staging=0, shadow=0, pending=0.
- FSM, one timer counting cycles within a state:
  - BLANK: anodes=8'hFF, segments=7'h7F, dp=1. After BLANK_CYCLES cycles -> SHOW, timer cleared.
  - SHOW:
    - anodes[digit_idx]=0 only if digit_en[digit_idx]=1 and digit_idx<DIGITS; otherwise all anodes are high.
    - segments = hex7(shadow nibble digit_idx); dp = ~dp_mask[digit_idx].
    - After PRESCALE cycles -> ADVANCE.
  - ADVANCE (exactly 1 cycle):
    - Outputs are the same as BLANK.
    - digit_idx <= (digit_idx==DIGITS-1) ? 0 : digit_idx+1.
    - Next state is BLANK.
- Slot length = BLANK_CYCLES + PRESCALE + 1 cycles. Frame length = DIGITS × slot.
- All outputs are registered. Anode, segment and dp changes occur on the same edge as the state change, with no combinational path from inputs to outputs.
- Wrap ADVANCE cycle (digit_idx==DIGITS-1):
  - frame_done=1 for that cycle only.
  - If pending=1: shadow<=staging, pending<=0, and load_ack=1 for that cycle.
- load handling:
  - Any cycle with load=1 sets staging<=value and pending<=1.
  - Repeated loads before a boundary: last value wins, and only one load_ack is issued.
  - A load in the same cycle as a wrap ADVANCE is captured into staging but applied at the next wrap. In that cycle, shadow takes the old staging if pending was already set.
- hex7 table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Boundary conditions:
  - digit_en=0 for all digits: scan continues, frame_done keeps pulsing, anodes stay 8'hFF.
  - Reset asserted mid-SHOW: outputs go to their reset values immediately. After release the scan restarts at digit 0 in BLANK, and any pending load is discarded.

Test Plan (PRESCALE=4, BLANK_CYCLES=2, DIGITS=8; slot=7 cycles, frame=56):
- Release reset, load=0 -> anodes=FF for 2 cycles, then 8'hFE with segments=1000000 for 4 cycles, then FF; the next lit slot has anodes=8'hFD; frame_done pulses every 56 cycles.
- Pulse load with value=32'h76543210 mid-frame -> display unchanged until wrap; load_ack and frame_done pulse together; the next frame shows digit0=1000000 and digit7 (anodes=8'h7F) = 1111000.
- Loads of 32'h11111111 then 32'hFFFFFFFF within one frame -> a single load_ack; every digit shows 0001110.
- digit_en=8'hF0, dp_mask=8'h01 -> slots 0-3 keep anodes=FF with dp=1 while frame timing is unchanged; slots 4-7 light with dp=1.
- DIGITS=4 -> digit_idx sequence 0,1,2,3,0; frame_done every 28 cycles; anodes[7:4] never low.
- Assert rst_n=0 during SHOW of digit 5 with load pending -> outputs go to FF/7F/1 asynchronously; after release, digit 0 is shown first, shadow=0, and no load_ack occurs.
